ffcp_tx_arbiter: RTL
====================

FFCP_TX_ARBITER -- requirements
Module: ffcp_tx_arbiter

Interface
REQ-001 Parameter FFCP_INDEX_LEN, default 6, width of the FFCP sequence index.
REQ-002 Parameter PB_POS_LEN, default 4, width of the packet-buffer position.
REQ-003 Parameter DONE_TIMEOUT, default 2000000, cycles to wait for tx_done before abandoning a transmission.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 ack_req  in  1  one-cycle ack request from the receive-side server.
REQ-007 ack_index  in  FFCP_INDEX_LEN  index to acknowledge; valid with ack_req.
REQ-008 data_req  in  1  one-cycle message request from the transmit-side server.
REQ-009 data_syn  in  1  request is a syn rather than a msg; valid with data_req.
REQ-010 data_index  in  FFCP_INDEX_LEN  message index; valid with data_req.
REQ-011 data_buf_pos  in  PB_POS_LEN  payload slot in the packet buffer; valid with data_req.
REQ-012 tx_done  in  1  one-cycle pulse from the packet transmitter when the frame has fully left.
REQ-013 tx_start  out  1  one-cycle start pulse to the FFCP transmitter.
REQ-014 tx_type  out  2  FFCP type for the frame: 0 syn, 1 msg, 2 ack.
REQ-015 tx_index  out  FFCP_INDEX_LEN  FFCP index for the frame.
REQ-016 tx_buf_pos  out  PB_POS_LEN  payload slot; meaningful only when tx_sel_data=1.
REQ-017 tx_sel_data  out  1  1 while a syn or msg owns the transmitter, 0 otherwise.
REQ-018 ack_done  out  1  one-cycle completion pulse to the receive-side server.
REQ-019 data_done  out  1  one-cycle completion pulse to the transmit-side server.
REQ-020 busy  out  1  1 whenever state is not IDLE.
REQ-021 timeout_err  out  1  one-cycle pulse when a transmission is abandoned.

Function
REQ-022 The arbiter SHALL keep two pending slots: ACK (index) and DATA (syn, index, buf_pos), each set by its request pulse.
REQ-023 An ack_req while ACK is pending SHALL overwrite the index, so the newest ack wins, and SHALL produce only one ack_done.
REQ-024 A data_req while DATA is pending SHALL be ignored.
REQ-025 The FSM SHALL have three states: IDLE, START and WAIT.
REQ-026 In IDLE with either slot pending, the FSM SHALL grant one slot, latch its fields onto the tx_* outputs, clear that slot and go to START.
REQ-027 If both slots are pending, the grant SHALL go to the kind not granted last; last_grant resets to DATA, so ACK wins the first tie.
REQ-028 START SHALL assert tx_start for exactly one cycle and then go to WAIT.
REQ-029 Latency: with a request sampled at edge k and the FSM in IDLE, tx_start SHALL be high in the cycle after edge k+1.
REQ-030 tx_type, tx_index, tx_buf_pos and tx_sel_data SHALL stay stable from START until the FSM returns to IDLE.
REQ-031 tx_type SHALL be 2 for ACK, 0 for DATA with syn=1, and 1 for DATA with syn=0.
REQ-032 tx_done SHALL be honoured only in WAIT and ignored in IDLE and START.
REQ-033 When tx_done arrives in WAIT, the FSM SHALL go to IDLE and pulse the granted kind's done output (registered) in the next cycle.
REQ-034 A 32-bit-or-wider watchdog SHALL clear on entry to WAIT and count each WAIT cycle.
REQ-035 When the watchdog reaches DONE_TIMEOUT-1 without tx_done, the arbiter SHALL pulse timeout_err and the granted done output together and go to IDLE.
REQ-036 A request for a slot arriving in the same cycle that slot is granted and cleared SHALL win: the slot stays set with the new fields.
REQ-037 Requests SHALL be latched in every state, so a new request arriving in WAIT is served after the current frame.
REQ-038 After REQ-033 the arbiter SHALL spend at least one cycle in IDLE before the next tx_start (back-to-back spacing of at least 3 cycles).

Reset
REQ-039 While rst_n=0, state SHALL be IDLE, both slots clear, last_grant=DATA, watchdog 0.
REQ-040 While rst_n=0, outputs SHALL be tx_start=0, ack_done=0, data_done=0, busy=0, timeout_err=0, tx_sel_data=0, tx_type=0, tx_index=0, tx_buf_pos=0.
REQ-041 Reset asserted mid-transmission SHALL abandon the transmission immediately and pulse no done output.

Verification
REQ-042 Single ack: ack_req with index 5, then tx_done 10 cycles after tx_start -> one tx_start with type 2, index 5, sel_data 0; ack_done 1 cycle after tx_done.
REQ-043 Tie: ack_req (3) and data_req (syn 0, index 7, pos 2) in the same cycle -> ack frame first, then msg type 1, index 7, pos 2; third tie -> ACK again.
REQ-044 Coalesce: ack_req with 3 then 4 before the grant -> one ack frame with index 4 and one ack_done.
REQ-045 Timeout with DONE_TIMEOUT=8 and tx_done never sent -> timeout_err and data_done together in WAIT cycle 8, then busy falls.
REQ-046 rst_n pulled low in WAIT -> outputs reach reset values asynchronously, no done pulse; a fresh request after release is served normally.

Source files
------------

// File: rtl/ffcp_tx_arbiter.sv
// Arbitrates between pending ACK and DATA (syn/msg) frames for the single FFCP transmitter,
// sequencing start, completion and watchdog timeout for each granted frame.
module ffcp_tx_arbiter #(
  parameter int unsigned FFCP_INDEX_LEN = 6,
  parameter int unsigned PB_POS_LEN     = 4,
  parameter int unsigned DONE_TIMEOUT   = 2000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ack_req,
  input  logic [FFCP_INDEX_LEN-1:0] ack_index,
  input  logic                      data_req,
  input  logic                      data_syn,
  input  logic [FFCP_INDEX_LEN-1:0] data_index,
  input  logic [PB_POS_LEN-1:0]     data_buf_pos,
  input  logic                      tx_done,
  output logic                      tx_start,
  output logic [1:0]                tx_type,
  output logic [FFCP_INDEX_LEN-1:0] tx_index,
  output logic [PB_POS_LEN-1:0]     tx_buf_pos,
  output logic                      tx_sel_data,
  output logic                      ack_done,
  output logic                      data_done,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int unsigned     WD_W     = 32;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(DONE_TIMEOUT - 1);
  localparam logic [1:0]      TYPE_SYN = 2'd0;
  localparam logic [1:0]      TYPE_MSG = 2'd1;
  localparam logic [1:0]      TYPE_ACK = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                    state, state_n;
  logic                      ack_pend, ack_pend_n;
  logic [FFCP_INDEX_LEN-1:0] ack_idx, ack_idx_n;
  logic                      data_pend, data_pend_n;
  logic                      data_syn_q, data_syn_n;
  logic [FFCP_INDEX_LEN-1:0] data_idx, data_idx_n;
  logic [PB_POS_LEN-1:0]     data_pos, data_pos_n;
  logic                      last_ack, last_ack_n;
  logic                      grant_ack, grant_ack_n;
  logic [WD_W-1:0]           wd, wd_n;

  logic                      tx_start_n;
  logic [1:0]                tx_type_n;
  logic [FFCP_INDEX_LEN-1:0] tx_index_n;
  logic [PB_POS_LEN-1:0]     tx_buf_pos_n;
  logic                      tx_sel_data_n;
  logic                      ack_done_n;
  logic                      data_done_n;
  logic                      busy_n;
  logic                      timeout_err_n;

  // State, pending slots and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ack_pend    <= 1'b0;
      ack_idx     <= '0;
      data_pend   <= 1'b0;
      data_syn_q  <= 1'b0;
      data_idx    <= '0;
      data_pos    <= '0;
      last_ack    <= 1'b0;
      grant_ack   <= 1'b0;
      wd          <= '0;
      tx_start    <= 1'b0;
      tx_type     <= '0;
      tx_index    <= '0;
      tx_buf_pos  <= '0;
      tx_sel_data <= 1'b0;
      ack_done    <= 1'b0;
      data_done   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      ack_pend    <= ack_pend_n;
      ack_idx     <= ack_idx_n;
      data_pend   <= data_pend_n;
      data_syn_q  <= data_syn_n;
      data_idx    <= data_idx_n;
      data_pos    <= data_pos_n;
      last_ack    <= last_ack_n;
      grant_ack   <= grant_ack_n;
      wd          <= wd_n;
      tx_start    <= tx_start_n;
      tx_type     <= tx_type_n;
      tx_index    <= tx_index_n;
      tx_buf_pos  <= tx_buf_pos_n;
      tx_sel_data <= tx_sel_data_n;
      ack_done    <= ack_done_n;
      data_done   <= data_done_n;
      busy        <= busy_n;
      timeout_err <= timeout_err_n;
    end
  end

  // Next-state, grant and slot update logic
  always_comb begin
    state_n       = state;
    ack_pend_n    = ack_pend;
    ack_idx_n     = ack_idx;
    data_pend_n   = data_pend;
    data_syn_n    = data_syn_q;
    data_idx_n    = data_idx;
    data_pos_n    = data_pos;
    last_ack_n    = last_ack;
    grant_ack_n   = grant_ack;
    wd_n          = wd;
    tx_start_n    = 1'b0;
    tx_type_n     = tx_type;
    tx_index_n    = tx_index;
    tx_buf_pos_n  = tx_buf_pos;
    tx_sel_data_n = tx_sel_data;
    ack_done_n    = 1'b0;
    data_done_n   = 1'b0;
    timeout_err_n = 1'b0;

    case (state)
      S_IDLE: begin
        // Ties go to the kind that did not win last time
        if (ack_pend && (!data_pend || !last_ack)) begin
          state_n       = S_START;
          ack_pend_n    = 1'b0;
          last_ack_n    = 1'b1;
          grant_ack_n   = 1'b1;
          tx_start_n    = 1'b1;
          tx_type_n     = TYPE_ACK;
          tx_index_n    = ack_idx;
          tx_buf_pos_n  = '0;
          tx_sel_data_n = 1'b0;
        end else if (data_pend) begin
          state_n       = S_START;
          data_pend_n   = 1'b0;
          last_ack_n    = 1'b0;
          grant_ack_n   = 1'b0;
          tx_start_n    = 1'b1;
          tx_type_n     = data_syn_q ? TYPE_SYN : TYPE_MSG;
          tx_index_n    = data_idx;
          tx_buf_pos_n  = data_pos;
          tx_sel_data_n = 1'b1;
        end
      end
      S_START: begin
        state_n = S_WAIT;
        wd_n    = '0;
        if (WD_LAST == '0) begin
          timeout_err_n = 1'b1;
          ack_done_n    = grant_ack;
          data_done_n   = !grant_ack;
        end
      end
      S_WAIT: begin
        // Timeout pulses are raised one edge early so they coincide with the last WAIT cycle
        if (wd == WD_LAST) begin
          state_n       = S_IDLE;
          tx_sel_data_n = 1'b0;
        end else if (tx_done) begin
          state_n       = S_IDLE;
          tx_sel_data_n = 1'b0;
          ack_done_n    = grant_ack;
          data_done_n   = !grant_ack;
        end else begin
          wd_n = wd + WD_W'(1);
          if (wd_n == WD_LAST) begin
            timeout_err_n = 1'b1;
            ack_done_n    = grant_ack;
            data_done_n   = !grant_ack;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // New requests win over a same-cycle grant clear; newest ack index overwrites
    if (ack_req) begin
      ack_pend_n = 1'b1;
      ack_idx_n  = ack_index;
    end
    if (data_req && !data_pend_n) begin
      data_pend_n = 1'b1;
      data_syn_n  = data_syn;
      data_idx_n  = data_index;
      data_pos_n  = data_buf_pos;
    end

    busy_n = (state_n != S_IDLE);
  end

endmodule
